fp_div_iter: RTL and testbench
==============================

Name: fp_div_iter

Overview:
- Parametrised multi-cycle IEEE-754-style floating-point divider for the MIPS FPU datapath (div.s path), replacing a single-cycle combinational divider.
- Radix-2 restoring division, one quotient bit per cycle.
- Supports four rounding modes and handles special operands.
- Uses a valid/ready handshake so the core can stall on FP divide.

Parameters:
- EXP_W, 8: exponent width; BIAS = 2^(EXP_W-1)-1.
- SIG_W, 23: stored fraction width; word width W = 1+EXP_W+SIG_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit idle, can accept
- a  in  W  dividend
- b  in  W  divisor
- rnd  in  2  rounding mode: 0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  W  quotient
- status  out  5  {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - Reset values: state IDLE, in_ready=1, out_valid=0, z=0, status=0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE (in_ready=1)
  - DIV (iterate; counter runs 0..SIG_W+2)
  - ROUND (normalise and round)
  - DONE (out_valid=1)
- Accept on in_valid&&in_ready. a, b and rnd are registered at that edge; later input changes are ignored.
- Denormal inputs (exp=0) are flushed to signed zero. Exponent all-ones with fraction nonzero is NaN.
- Special cases (IDLE goes to DONE directly; out_valid high the cycle after accept):
  - NaN operand, 0/0, or inf/inf -> z=0 sign, exp all-ones, fraction MSB 1 (0x7FC00000 at default); invalid=1.
  - finite nonzero / 0 -> signed inf; divzero=1.
  - inf / finite -> signed inf.
  - finite / inf, or 0 / nonzero -> signed zero.
  - All other flags are 0 for special cases.
- Sign = sa^sb in all non-NaN cases.
- Normal path:
  - ma={1,fa}, mb={1,fb}.
  - Produce SIG_W+3 quotient bits q of (ma/mb)·2^(SIG_W+2), one bit per DIV cycle. Remainder is kept in SIG_W+2 bits.
  - Exponent e = ea-eb+BIAS, computed signed in EXP_W+2 bits.
- ROUND:
  - If q[SIG_W+2]=1: sig=q[SIG_W+2:2], guard=q[1], sticky=q[0]|(rem!=0).
  - Else: sig=q[SIG_W+1:1], guard=q[0], sticky=(rem!=0), and e=e-1.
  - Increment sig when:
    - RNE: guard&&(sticky||sig[0]).
    - RTZ: never.
    - +inf: !sign&&(guard||sticky).
    - -inf: sign&&(guard||sticky).
  - Carry out of sig sets sig=1.0 and e=e+1.
  - inexact = guard||sticky.
  - Overflow when e >= 2^EXP_W-1:
    - RNE: result is inf.
    - RTZ: result is max finite.
    - Directed modes: inf if rounding away from zero, else max finite.
    - Flags: overflow=1, inexact=1.
  - Underflow when e <= 0: result is signed zero (flush); flags underflow=1, inexact=1.
- Latency:
  - Normal path: accept edge E0; out_valid high after edge E0+SIG_W+4 (27 for default).
  - Special cases: 1 cycle.
- Output:
  - z and status are stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE. in_ready rises the next cycle (no same-cycle re-accept).
  - z and status hold their last values in IDLE.

Optional Feature:
- Macro FP_DIV_STATUS_EN.
- Defined: the status port is driven as described above.
- Undefined: status is tied to 5'b0 and no flag logic is synthesised. z, latency and handshake are unchanged.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), rnd=0 -> z=0x40400000, status=0, out_valid exactly 27 cycles after accept.
- a=0x3F800000, b=0x40400000 (1/3):
  - rnd=0 -> z=0x3EAAAAAB, inexact=1.
  - rnd=1 -> z=0x3EAAAAAA.
- Special operands:
  - a=0x3F800000, b=0 -> z=0x7F800000, divzero=1, 1-cycle latency.
  - a=0, b=0 -> z=0x7FC00000, invalid=1.
- a=0x7F000000, b=0x00800000:
  - rnd=0 -> z=0x7F800000, overflow=1, inexact=1.
  - rnd=1 -> z=0x7F7FFFFF.
- a=0x00800000, b=0x7F000000 -> z=0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> z and status stable, in_ready=0. Then pulse out_ready -> in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 at cycle 10 of DIV -> the next cycle shows in_ready=1, out_valid=0, z=0. A following 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/fp_div_iter.sv
// fp_div_iter: multi-cycle radix-2 restoring floating-point divider with valid/ready handshake
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake; a, b, rnd captured on accept
//   a, b                  dividend, divisor (W = 1+EXP_W+SIG_W bits)
//   rnd                   0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
//   out_valid / out_ready result handshake; z and status held until taken
//   z                     quotient
//   status                {invalid, divzero, overflow, underflow, inexact}
// Define FP_DIV_STATUS_EN to drive status; otherwise status is tied to zero.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23,
    localparam int W = 1 + EXP_W + SIG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   rnd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [4:0]   status
);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(SIG_W + 3);
    localparam logic [CW-1:0] LAST = CW'(SIG_W + 2);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
    state_t state, state_nx;

    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [SIG_W-1:0]     fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                 sp_nan, special, sgn_in, accept;
    logic [W-1:0]         sp_z;

    logic [1:0]           rnd_q;
    logic                 sign_q;
    logic [SIG_W+1:0]     rem, rem_nx, mb_q;
    logic [SIG_W+2:0]     q;
    logic [EW-1:0]        e_q, e1, e2;
    logic [CW-1:0]        cnt;
    logic [W-1:0]         z_q, rd_z;
    logic                 ge, hi, guard, sticky, inc, away, ovf, udf;
    logic [SIG_W:0]       sig;
    logic [SIG_W+1:0]     sum;
    logic                 unused_hidden;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;

    // Denormals (exp 0) are treated as signed zero.
    always_comb begin
        a_zero  = ea == '0;
        b_zero  = eb == '0;
        a_inf   = &ea && fa == '0;
        b_inf   = &eb && fb == '0;
        a_nan   = &ea && fa != '0;
        b_nan   = &eb && fb != '0;
        sgn_in  = sa ^ sb;
        sp_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
        special = sp_nan || a_inf || b_inf || a_zero || b_zero;
        accept  = in_valid && in_ready;
        sp_z    = sp_nan ? {1'b0, EXP_ONES, 1'b1, {(SIG_W-1){1'b0}}} :
                  (a_inf || b_zero) ? {sgn_in, EXP_ONES, {SIG_W{1'b0}}} :
                  {sgn_in, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? (special ? DONE : DIV) : IDLE;
            DIV:   state_nx = (cnt == LAST) ? ROUND : DIV;
            ROUND: state_nx = DONE;
            DONE:  state_nx = out_ready ? IDLE : DONE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // One restoring step per DIV cycle; the remainder is stored pre-shifted,
    // which loses nothing because it is always below the divisor.
    always_comb begin
        ge     = rem >= mb_q;
        rem_nx = ge ? rem - mb_q : rem;
    end

    always_comb begin
        hi     = q[SIG_W+2];
        sig    = hi ? q[SIG_W+2:2] : q[SIG_W+1:1];
        guard  = hi ? q[1] : q[0];
        sticky = (hi && q[0]) || rem != '0;
        e1     = hi ? e_q : e_q - EW'(1);
        inc    = rnd_q == 2'd0 ? guard && (sticky || sig[0]) :
                 rnd_q == 2'd1 ? 1'b0 :
                 rnd_q == 2'd2 ? !sign_q && (guard || sticky) :
                 sign_q && (guard || sticky);
        sum    = {1'b0, sig} + {{(SIG_W+1){1'b0}}, inc};
        // A carry out leaves the fraction bits at zero, i.e. 1.0 at e+1.
        e2     = e1 + {{(EW-1){1'b0}}, sum[SIG_W+1]};
        ovf    = !e2[EW-1] && e2[EW-2:0] >= (EW-1)'(2 ** EXP_W - 1);
        udf    = e2[EW-1] || e2 == '0;
        away   = rnd_q == 2'd0 ? 1'b1 :
                 rnd_q == 2'd1 ? 1'b0 :
                 rnd_q == 2'd2 ? !sign_q : sign_q;
        rd_z   = ovf ? (away ? {sign_q, EXP_ONES, {SIG_W{1'b0}}} :
                               {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}}) :
                 udf ? {sign_q, {(W-1){1'b0}}} :
                 {sign_q, e2[EXP_W-1:0], sum[SIG_W-1:0]};
    end

    assign unused_hidden = sum[SIG_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q    <= '0;
            rnd_q  <= '0;
            sign_q <= 1'b0;
            rem    <= '0;
            mb_q   <= '0;
            e_q    <= '0;
            q      <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                rnd_q  <= rnd;
                sign_q <= sgn_in;
                rem    <= {2'b01, fa};
                mb_q   <= {2'b01, fb};
                e_q    <= EW'(ea) - EW'(eb) + EW'(BIAS);
                q      <= '0;
                cnt    <= '0;
                if (special)
                    z_q <= sp_z;
            end
            if (state == DIV) begin
                q   <= {q[SIG_W+1:0], ge};
                rem <= rem_nx << 1;
                cnt <= cnt + CW'(1);
            end
            if (state == ROUND)
                z_q <= rd_z;
        end
    end

    assign z = z_q;

`ifdef FP_DIV_STATUS_EN
    logic [4:0] st_q, sp_st, rd_st;

    always_comb begin
        sp_st = {sp_nan, !sp_nan && !a_inf && b_zero, 3'b000};
        rd_st = ovf ? 5'b00101 : udf ? 5'b00011 : {4'b0000, guard || sticky};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            st_q <= '0;
        else if (accept && special)
            st_q <= sp_st;
        else if (state == ROUND)
            st_q <= rd_st;
    end

    assign status = st_q;
`else
    assign status = '0;
`endif
endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed vectors against an arithmetic reference model for fp_div_iter
module tb_fp_div_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] a = '0, b = '0, z;
    logic [1:0]  rnd = '0;
    logic [4:0]  status;

`ifdef FP_DIV_STATUS_EN
    localparam bit ST_EN = 1'b1;
`else
    localparam bit ST_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_div_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .status(status)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact integer quotient with remainder, then the rounding rules.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] r,
                                  output logic [31:0] mz, output logic [4:0] mst);
        int ex, ey, e;
        longint unsigned mx, my, num, qt, rm, sg;
        logic s, g, sk, up, xz, yz, xi, yi, xn, yn, aw;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = ex == 0;
        yz = ey == 0;
        xi = ex == 255 && x[22:0] == 0;
        yi = ey == 255 && y[22:0] == 0;
        xn = ex == 255 && x[22:0] != 0;
        yn = ey == 255 && y[22:0] != 0;
        s = x[31] ^ y[31];
        mst = 5'b0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            mz = 32'h7FC00000;
            mst = 5'b10000;
        end else if (xi) begin
            mz = {s, 8'hFF, 23'h0};
        end else if (yz) begin
            mz = {s, 8'hFF, 23'h0};
            mst = 5'b01000;
        end else if (xz || yi) begin
            mz = {s, 31'h0};
        end else begin
            mx = 64'(x[22:0]) + 64'h800000;
            my = 64'(y[22:0]) + 64'h800000;
            num = mx << 25;
            qt = num / my;
            rm = num % my;
            e = ex - ey + 127;
            if (qt >= 64'h2000000) begin
                sg = qt >> 2;
                g = qt[1];
                sk = qt[0] || rm != 0;
            end else begin
                sg = qt >> 1;
                g = qt[0];
                sk = rm != 0;
                e = e - 1;
            end
            case (r)
                2'd0: up = g && (sk || sg[0]);
                2'd1: up = 1'b0;
                2'd2: up = !s && (g || sk);
                default: up = s && (g || sk);
            endcase
            sg = sg + 64'(up);
            if (sg == 64'h1000000) begin
                sg = 64'h800000;
                e = e + 1;
            end
            aw = r == 2'd0 ? 1'b1 : r == 2'd1 ? 1'b0 : r == 2'd2 ? !s : s;
            if (e >= 255) begin
                mz = aw ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
                mst = 5'b00101;
            end else if (e <= 0) begin
                mz = {s, 31'h0};
                mst = 5'b00011;
            end else begin
                mz = {s, 8'(e), sg[22:0]};
                mst = {4'b0, g || sk};
            end
        end
    endfunction

    typedef struct packed {
        logic [31:0] z;
        logic [4:0]  st;
    } exp_t;
    exp_t exp_q[$];

    // Every cycle a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", {31'b0, out_valid}, 32'd0);
            end else begin
                check("z", z, exp_q[0].z);
                check("status", {27'b0, status}, {27'b0, exp_q[0].st});
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  r;
        logic [31:0] z;
        logic [4:0]  st;
        logic [7:0]  lat;
        logic [3:0]  hold;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV] = '{
        '{32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 8'd27, 4'd0},
        '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, 8'd27, 4'd5},
        '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, 8'd27, 4'd0},
        '{32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAB, 5'b00001, 8'd27, 4'd0},
        '{32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAB, 5'b00001, 8'd27, 4'd0},
        '{32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAA, 5'b00001, 8'd27, 4'd0},
        '{32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b01000, 8'd0,  4'd0},
        '{32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000, 8'd0,  4'd3},
        '{32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000, 8'd0,  4'd0},
        '{32'h7F800000, 32'h7F800000, 2'd0, 32'h7FC00000, 5'b10000, 8'd0,  4'd0},
        '{32'h7F800000, 32'hC0000000, 2'd0, 32'hFF800000, 5'b00000, 8'd0,  4'd0},
        '{32'h40000000, 32'h7F800000, 2'd0, 32'h00000000, 5'b00000, 8'd0,  4'd0},
        '{32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 5'b00000, 8'd0,  4'd0},
        '{32'h00400000, 32'h3F800000, 2'd0, 32'h00000000, 5'b00000, 8'd0,  4'd0},
        '{32'h7F000000, 32'h00800000, 2'd0, 32'h7F800000, 5'b00101, 8'd27, 4'd0},
        '{32'h7F000000, 32'h00800000, 2'd1, 32'h7F7FFFFF, 5'b00101, 8'd27, 4'd0},
        '{32'hFF000000, 32'h00800000, 2'd2, 32'hFF7FFFFF, 5'b00101, 8'd27, 4'd0},
        '{32'hFF000000, 32'h00800000, 2'd3, 32'hFF800000, 5'b00101, 8'd27, 4'd0},
        '{32'h7F000000, 32'h3F000000, 2'd0, 32'h7F800000, 5'b00101, 8'd27, 4'd0},
        '{32'h7F000000, 32'h3F800000, 2'd0, 32'h7F000000, 5'b00000, 8'd27, 4'd0},
        '{32'h00800000, 32'h7F000000, 2'd0, 32'h00000000, 5'b00011, 8'd27, 4'd0},
        '{32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00011, 8'd27, 4'd0},
        '{32'h00800000, 32'h3F800000, 2'd0, 32'h00800000, 5'b00000, 8'd27, 4'd0},
        '{32'h3F800000, 32'h00400000, 2'd0, 32'h7F800000, 5'b01000, 8'd0,  4'd0},
        '{32'h40C00000, 32'hC0000000, 2'd0, 32'hC0400000, 5'b00000, 8'd27, 4'd0}
    };

    // Latency is counted in clock edges after the accepting edge.
    task automatic run(input vec_t v);
        logic [31:0] mz;
        logic [4:0]  mst;
        int lat, w;
        model(v.a, v.b, v.r, mz, mst);
        check("model_z", mz, v.z);
        check("model_status", {27'b0, mst}, {27'b0, v.st});
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        a = v.a;
        b = v.b;
        rnd = v.r;
        in_valid = 1'b1;
        exp_q.push_back('{mz, ST_EN ? mst : 5'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 32'hFFFFFFFF;
        b = 32'h00000000;
        rnd = 2'd3;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("edges_to_out_valid", lat, 32'(v.lat));
        check("in_ready_busy", {31'b0, in_ready}, 32'd0);
        repeat (int'(v.hold)) begin
            @(posedge clk);
            #1;
            check("in_ready_backpressure", {31'b0, in_ready}, 32'd0);
            check("out_valid_backpressure", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_take", {31'b0, in_ready}, 32'd1);
        check("out_valid_after_take", {31'b0, out_valid}, 32'd0);
        check("z_held_idle", z, mz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_z", z, 32'd0);
        check("reset_status", {27'b0, status}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++)
            run(vecs[i]);
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        rnd = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_reset", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midreset_z", z, 32'd0);
        check("midreset_status", {27'b0, status}, 32'd0);
        rst_n = 1'b1;
        run(vecs[0]);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
